// File: rtl/dmem_ctrl_pkg.sv
// dmem_defs: shared encodings for the data-memory controller
package dmem_defs;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_WAIT = 2'b01, ST_DONE = 2'b10} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
module dmem_lane_align
  import dmem_defs::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misalign
);
  logic [7:0]  rb;
  logic [15:0] rh;
  // Replicating the right-aligned store data puts it on every candidate lane; the mask picks which lanes commit
  always_comb begin
    rb = rword[{addr, 3'b000} +: 8];
    rh = rword[{addr[1], 4'b0000} +: 16];
    misalign = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    mask = size == SZ_BYTE ? 4'b0001 << addr :
           size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
    wword = size == SZ_BYTE ? {4{wdata[7:0]}} :
            size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rext = size == SZ_BYTE ? {{24{~uns & rb[7]}}, rb} :
           size == SZ_HALF ? {{16{~uns & rh[15]}}, rh} : rword;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller over a word-organised RAM with wait states
module dmem_ctrl
  import dmem_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] a_q, wd_q;
  logic [1:0] sz_q;
  logic uns_q, rd_q, wr_q;
  logic [31:0] mem [0:DEPTH_WORDS-1];
  logic [3:0] mask;
  logic [31:0] wword, rext;
  logic misalign, range_err, bad, req, access;
  assign req = !cs_n && (rd || wr);
  assign access = state == ST_WAIT && cnt == '0;
  assign range_err = {2'b00, a_q[31:2]} >= 32'(DEPTH_WORDS);
  assign bad = (rd_q && wr_q) || sz_q == SZ_RSVD || misalign || range_err;
  dmem_lane_align u_align (
    .addr(a_q[1:0]), .size(sz_q), .uns(uns_q), .wdata(wd_q), .rword(mem[a_q[AW+1:2]]),
    .mask(mask), .wword(wword), .rext(rext), .misalign(misalign)
  );
  // State register
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : nxt;
  // Next state: accept in IDLE, count down in WAIT, DONE lasts exactly one cycle
  always_comb begin
    nxt = ST_IDLE;
    nxt = state == ST_IDLE ? (req ? ST_WAIT : ST_IDLE) :
          state == ST_WAIT ? (cnt == '0 ? ST_DONE : ST_WAIT) : ST_IDLE;
  end
  // Request latch, wait counter and registered response (response is zero outside DONE)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= access;
      err <= access && bad;
      rdata <= (access && !bad && rd_q) ? rext : '0;
      if (state == ST_IDLE && req) begin
        cnt <= CNT_W'(WAIT_STATES);
        a_q <= addr;
        wd_q <= wdata;
        sz_q <= size;
        uns_q <= uns;
        rd_q <= rd;
        wr_q <= wr;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  // Store commit on the edge that enters DONE; reset on that edge drops it
  always_ff @(posedge clk)
    if (!rst && access && !bad && wr_q)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[a_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with zero and three wait states
module tb_dmem_ctrl;
  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2], cs_n [2], rd [2], wr [2], uns [2], ready [2], err [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [1:0] size [2];
  exp_t q [2][$];
  logic [7:0] mm [2][256];
  logic [31:0] last [2];
  logic last_err [2];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t mon_e;
  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst[0]), .cs_n(cs_n[0]), .rd(rd[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .size(size[0]), .uns(uns[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
  );
  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst[1]), .cs_n(cs_n[1]), .rd(rd[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .size(size[1]), .uns(uns[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
  );
  always @(posedge clk) cyc++;
  function automatic int ws(input int d);
    return d == 0 ? 0 : 3;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference model: byte-addressed little-endian memory, errors from the access rules
  task automatic model(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input bit u,
                       output logic [31:0] er, output bit ee);
    int nb;
    logic [31:0] v;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    ee = (r && w) || sz == 2'd3 || (a % nb) != 0 || (a >> 2) >= 1024;
    er = '0;
    if (!ee && w)
      for (int i = 0; i < nb; i++) mm[d][a + i] = wd[8*i +: 8];
    if (!ee && r) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | ({24'b0, mm[d][a + i]} << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      er = v;
    end
  endtask
  // Monitor: every ready pulse must match the oldest expectation, including its arrival cycle
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (ready[d]) begin
        if (q[d].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready dut%0d: got ready=1 expected no pulse at cycle %0d", d, cyc);
        end else begin
          mon_e = q[d].pop_front();
          chk($sformatf("rdata_dut%0d", d), rdata[d], mon_e.rd);
          chk($sformatf("err_dut%0d", d), {31'b0, err[d]}, {31'b0, mon_e.e});
          chk($sformatf("latency_dut%0d", d), cyc, mon_e.cyc);
          last[d] = rdata[d];
          last_err[d] = err[d];
        end
      end
  // Issue one request (entered #1 after a rising edge), hold it until ready, then release it
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz, input bit u, input bit scramble);
    logic [31:0] er;
    bit ee;
    exp_t e;
    int n;
    model(d, r, w, a, wd, sz, u, er, ee);
    e.rd = er;
    e.e = ee;
    e.cyc = cyc + ws(d) + 2;
    q[d].push_back(e);
    cs_n[d] = 1'b0; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; size[d] = sz; uns[d] = u;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n >= 2 && !ready[d]) begin
        addr[d] = $urandom; wdata[d] = $urandom; size[d] = 2'($urandom); uns[d] = 1'($urandom);
      end
    end while (!ready[d] && n < 40);
    if (!ready[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: got no ready expected one within 40 cycles", d);
      q[d].delete();
    end
    @(posedge clk);
    #1;
    cs_n[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
  endtask
  task automatic rand_txn(input int d);
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 19);
    a = $urandom_range(0, 255);
    if (k == 19) a = 32'h1000 + $urandom_range(0, 4095);
    txn(d, k < 9 || k == 18, k >= 9, a, $urandom, k == 17 ? 2'd3 : 2'($urandom_range(0, 2)), 1'($urandom), 1'b0);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cs_n[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; size[d] = 2'd0; uns[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_dut%0d", d), {31'b0, ready[d]}, 32'd0);
      chk($sformatf("reset_err_dut%0d", d), {31'b0, err[d]}, 32'd0);
      chk($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'd0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) txn(d, 1'b0, 1'b1, 32'(w * 4), 32'd0, 2'd2, 1'b0, 1'b0);
    txn(0, 1, 0, 32'h10, 0, 2'd2, 0, 0);
    chk("init_zero", last[0], 32'h0);
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0);
    txn(0, 1, 0, 32'h10, 0, 2'd2, 0, 0);
    chk("word_load", last[0], 32'hDEADBEEF);
    txn(0, 0, 1, 32'h20, 32'h11223344, 2'd2, 0, 0);
    txn(0, 0, 1, 32'h22, 32'h00000080, 2'd0, 0, 0);
    txn(0, 1, 0, 32'h22, 0, 2'd0, 0, 0);
    chk("byte_signed", last[0], 32'hFFFFFF80);
    txn(0, 1, 0, 32'h22, 0, 2'd0, 1, 0);
    chk("byte_unsigned", last[0], 32'h00000080);
    txn(0, 1, 0, 32'h20, 0, 2'd2, 0, 0);
    chk("byte_lane_word", last[0], 32'h11803344);
    txn(0, 0, 1, 32'h30, 32'h0000BEEF, 2'd1, 0, 0);
    txn(0, 1, 0, 32'h30, 0, 2'd1, 0, 0);
    chk("half_signed", last[0], 32'hFFFFBEEF);
    txn(0, 0, 1, 32'h31, 32'h00001234, 2'd1, 0, 0);
    chk("half_misalign_err", {31'b0, last_err[0]}, 32'd1);
    txn(0, 1, 0, 32'h31, 0, 2'd1, 0, 0);
    chk("half_misalign_rdata", last[0], 32'h0);
    txn(0, 1, 0, 32'h30, 0, 2'd2, 0, 0);
    chk("half_ram_unchanged", last[0], 32'h0000BEEF);
    txn(0, 1, 0, 32'h1000, 0, 2'd2, 0, 0);
    chk("range_err", {31'b0, last_err[0]}, 32'd1);
    txn(0, 1, 1, 32'h10, 32'h5, 2'd2, 0, 0);
    chk("rdwr_err", {31'b0, last_err[0]}, 32'd1);
    txn(0, 1, 0, 32'h10, 0, 2'd3, 0, 0);
    chk("rsvd_err", {31'b0, last_err[0]}, 32'd1);
    txn(1, 0, 1, 32'h8, 32'h12345678, 2'd2, 0, 0);
    txn(1, 1, 0, 32'h8, 0, 2'd2, 0, 1);
    chk("ws3_scrambled_load", last[1], 32'h12345678);
    cs_n[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hCAFEF00D; size[1] = 2'd2;
    @(posedge clk);
    #1;
    rst[1] = 1'b1; cs_n[1] = 1'b1; wr[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, ready[1]}, 32'd0);
    chk("abort_rdata", rdata[1], 32'd0);
    chk("abort_err", {31'b0, err[1]}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    txn(1, 1, 0, 32'h40, 0, 2'd2, 0, 0);
    chk("abort_store_dropped", last[1], 32'h0);
    for (int i = 0; i < 150; i++) begin
      rand_txn(0);
      rand_txn(1);
    end
    repeat (4) @(posedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("pending_dut%0d", d), q[d].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that sits directly downstream of the core's data port. It accepts one load or store per transaction from the core's MEM stage and performs byte, halfword or word access into an internal word-organised RAM, with a configurable number of wait states. It returns sign- or zero-extended load data with a single-cycle `ready` pulse and flags misaligned, out-of-range and malformed requests.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `WAIT_STATES`, 0: extra cycles inserted before each access; range 0–15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cs_n` in 1: request strobe, active-low.
- `rd` in 1: load request.
- `wr` in 1: store request.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `uns` in 1: load extension; 1 zero-extends, 0 sign-extends.
- `rdata` out 32: extended load data; valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: error flag; valid only while `ready`=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: accepts a request when `cs_n`=0 and `rd` or `wr`=1. At the accept edge, latches `addr`, `wdata`, `size`, `uns` and the op, loads `cnt`=WAIT_STATES, and moves to WAIT.
- Inputs are ignored outside IDLE. Only latched values are used, so changes to the request mid-transaction have no effect.
- WAIT: if `cnt`≠0, decrements `cnt`. If `cnt`=0, performs the access and moves to DONE on that edge.
- DONE: `ready`=1 for exactly one cycle, then the FSM returns to IDLE.
- Error conditions. `err`=1; the RAM is not written and `rdata`=0.
  - `rd` and `wr` both 1 at accept.
  - `size`=11.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - Word index `addr[31:2]` ≥ DEPTH_WORDS.
- Store lanes:
  - Byte writes lane `addr[1:0]` with `wdata[7:0]`.
  - Half writes lanes {`addr[1]`*2+1, `addr[1]`*2} with `wdata[15:0]`.
  - Word writes all lanes.
  - Unselected lanes keep their contents.
- Load: extracts the same lanes and extends them to 32 bits per `uns`. Word loads ignore `uns`.
- `rdata` on a successful store is 0.

## Timing
- Reset values: state IDLE, `cnt`=0, `ready`=0, `err`=0, `rdata`=0. RAM contents are not cleared.
- Latency: request sampled at edge E0, then `ready`=1 in the cycle following edge E0+WAIT_STATES+1. That is WAIT_STATES+2 cycles from the request's first cycle.
- Throughput: one transaction per WAIT_STATES+3 cycles.
- Requester holds the request until it sees `ready`, then deasserts `cs_n` in the next cycle. If `cs_n` is still low in the cycle after DONE, that is a new request.
- Store commit happens on the same edge DONE is entered. A load issued immediately afterwards returns the new data.
- `rst` asserted in any state: the FSM is forced to IDLE at that edge with reset output values. An in-flight store that has not yet reached its commit edge is dropped. No `ready` pulse is produced for an aborted transaction.
- `cs_n`=0 with `rd`=`wr`=0 is not a request and leaves the FSM in IDLE.
- Address bits above log2(DEPTH_WORDS)+1 are checked for range only, never wrapped.

## Structure
- Shared package `dmem_defs`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state encoding (2 bits)
  - WAIT_STATES width constant (4)
- Sub-module `dmem_lane_align` (combinational):
  - Inputs: `addr[1:0]`, `size`, `uns`, `wdata`, RAM read word.
  - Outputs: 4-bit lane write mask, lane-shifted write word, extended load word, misalign flag.
- The top holds the FSM, wait counter, latched request, range check and RAM array (`reg [31:0] mem [0:DEPTH_WORDS-1]`).

## Test plan
- Word store/load, WAIT_STATES=0: store 0xDEADBEEF to 0x10, then load 0x10 → `ready` two cycles after each request, `rdata`=0xDEADBEEF, `err`=0.
- Byte lanes:
  - Store 0x11223344 to 0x20, then byte-store 0x80 to 0x22.
  - Signed byte load at 0x22 → 0xFFFFFF80.
  - Unsigned byte load at 0x22 → 0x00000080.
  - Word load at 0x20 → 0x11803344.
- Halfword plus misalign: half-store 0xBEEF to 0x30 and signed load → 0xFFFFBEEF. Half load at 0x31 → `err`=1, `rdata`=0, RAM unchanged.
- Errors:
  - Word access at 0x4 × DEPTH_WORDS → `err`=1.
  - `rd`=`wr`=1 → `err`=1.
  - `size`=11 → `err`=1.
  - Each completes with `ready` at normal latency.
- Wait states, WAIT_STATES=3: load → `ready` exactly 5 cycles after the request's first cycle. Changing `addr` during WAIT does not alter `rdata`.
- Reset mid-op, WAIT_STATES=3: store 0xCAFEF00D to 0x40 over prior value 0x0. Assert `rst` one cycle after accept → no `ready` pulse, outputs 0. A later load of 0x40 returns 0x00000000.
